// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control logic.
// Hazard-controller states and the load-use register compare live here.
package mips_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  // A load into $zero never produces a value, so it can never cause a stall.
  function automatic logic load_use_hit(
    input logic             memread,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt
  );
    return memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {WIDTH{1'b1}})) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, taken-branch
// and memory-handshake hazards, with a stall-cycle counter and timeout flag.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             branch_taken,
  input  logic             exmem_memaccess,
  input  logic             mem_ready,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             memwb_enable,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [15:0] WCNT_LAST = 16'(MEM_TIMEOUT - 1);

  hz_state_t   r_state;
  hz_state_t   w_state_next;
  logic [15:0] r_wcnt;
  logic [15:0] w_wcnt_next;
  logic        r_mem_timeout;
  logic        w_mem_busy;
  logic        w_load_use;

  assign w_mem_busy = exmem_memaccess && !mem_ready;
  assign w_load_use = load_use_hit(idex_memread, idex_rt, ifid_rs, ifid_rt);

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    pc_enable    = 1'b0;
    ifid_enable  = 1'b0;
    ifid_flush   = 1'b0;
    idex_enable  = 1'b0;
    idex_flush   = 1'b0;
    exmem_enable = 1'b0;
    memwb_enable = 1'b0;

    if (reset) begin
      case (r_state)
        RUN: begin
          if (w_mem_busy) begin
            w_state_next = MEM_WAIT;
            w_wcnt_next  = '0;
          end
        end
        MEM_WAIT: begin
          if (!w_mem_busy) begin
            w_state_next = RUN;
          end else if (r_wcnt >= WCNT_LAST) begin
            w_state_next = ERROR;
          end else begin
            w_wcnt_next = r_wcnt + 16'd1;
          end
        end
        ERROR:   w_state_next = ERROR;
        default: w_state_next = RUN;
      endcase

      // A frozen pipeline holds branch_taken, so it re-presents once memory answers.
      if ((r_state != ERROR) && !w_mem_busy) begin
        pc_enable    = 1'b1;
        ifid_enable  = 1'b1;
        idex_enable  = 1'b1;
        exmem_enable = 1'b1;
        memwb_enable = 1'b1;
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_load_use) begin
          pc_enable   = 1'b0;
          ifid_enable = 1'b0;
          idex_flush  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= RUN;
      r_wcnt        <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
      if (w_state_next == ERROR) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign mem_timeout = r_mem_timeout;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (!pc_enable),
    .clr  (1'b0),
    .q    (stall_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
// Each step's expected outputs are queued when driven and popped when checked.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  // Control vector order: {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en}
  localparam logic [6:0] C_RUN = 7'b1101011;
  localparam logic [6:0] C_BR  = 7'b1111111;
  localparam logic [6:0] C_LU  = 7'b0001111;
  localparam logic [6:0] C_FRZ = 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             branch_taken;
  logic             exmem_memaccess;
  logic             mem_ready;
  logic             pc_enable;
  logic             ifid_enable;
  logic             ifid_flush;
  logic             idex_enable;
  logic             idex_flush;
  logic             exmem_enable;
  logic             memwb_enable;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .idex_memread   (idex_memread),
    .idex_rt        (idex_rt),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .branch_taken   (branch_taken),
    .exmem_memaccess(exmem_memaccess),
    .mem_ready      (mem_ready),
    .pc_enable      (pc_enable),
    .ifid_enable    (ifid_enable),
    .ifid_flush     (ifid_flush),
    .idex_enable    (idex_enable),
    .idex_flush     (idex_flush),
    .exmem_enable   (exmem_enable),
    .memwb_enable   (memwb_enable),
    .mem_timeout    (mem_timeout),
    .stall_count    (stall_count)
  );

  logic [6:0] w_ctl;
  assign w_ctl = {pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
                  exmem_enable, memwb_enable};

  typedef struct {
    logic             rst;
    logic             mr;
    logic [4:0]       ex_rt;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             br;
    logic             ma;
    logic             rdy;
    logic [6:0]       ctl;
    logic [CNT_W-1:0] cnt;
    logic             to;
  } step_t;

  step_t sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic step_t mk(input int rst, input int mr, input int ex_rt, input int rs,
                               input int rt, input int br, input int ma, input int rdy,
                               input logic [6:0] ctl, input int cnt, input int to);
    step_t s;
    s.rst   = (rst != 0);
    s.mr    = (mr != 0);
    s.ex_rt = 5'(ex_rt);
    s.rs    = 5'(rs);
    s.rt    = 5'(rt);
    s.br    = (br != 0);
    s.ma    = (ma != 0);
    s.rdy   = (rdy != 0);
    s.ctl   = ctl;
    s.cnt   = CNT_W'(cnt);
    s.to    = (to != 0);
    return s;
  endfunction

  task automatic drive(input step_t s);
    @(negedge clk);
    reset           = s.rst;
    idex_memread    = s.mr;
    idex_rt         = s.ex_rt;
    ifid_rs         = s.rs;
    ifid_rt         = s.rt;
    branch_taken    = s.br;
    exmem_memaccess = s.ma;
    mem_ready       = s.rdy;
    sb.push_back(s);
  endtask

  task automatic test_reset();
    step_t t[$];
    step_t e;
    t.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 0, 0));
    t.push_back(mk(0, 1, 8, 8, 0, 0, 0, 0, C_FRZ, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (w_ctl !== e.ctl) begin
        errors++;
        $display("FAIL reset[%0d] ctl got %b want %b", i, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({stall_count, mem_timeout} !== {e.cnt, e.to}) begin
        errors++;
        $display("FAIL reset[%0d] cnt/to got %0d/%b want %0d/%b", i, stall_count, mem_timeout, e.cnt, e.to);
      end
      $display("reset[%0d] ctl=%b cnt=%0d to=%b", i, w_ctl, stall_count, mem_timeout);
    end
  endtask

  task automatic test_load_use();
    step_t t[$];
    step_t e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 0, 0));
    t.push_back(mk(1, 1, 8, 8, 0, 0, 0, 0, C_LU, 1, 0));
    t.push_back(mk(1, 0, 0, 8, 0, 0, 1, 1, C_RUN, 1, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (w_ctl !== e.ctl) begin
        errors++;
        $display("FAIL load_use[%0d] ctl got %b want %b", i, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({stall_count, mem_timeout} !== {e.cnt, e.to}) begin
        errors++;
        $display("FAIL load_use[%0d] cnt/to got %0d/%b want %0d/%b", i, stall_count, mem_timeout, e.cnt, e.to);
      end
      $display("load_use[%0d] ctl=%b cnt=%0d to=%b", i, w_ctl, stall_count, mem_timeout);
    end
  endtask

  task automatic test_no_stall();
    step_t t[$];
    step_t e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 0, 0));
    t.push_back(mk(1, 1, 0, 3, 0, 0, 0, 0, C_RUN, 0, 0));
    t.push_back(mk(1, 1, 9, 8, 10, 0, 0, 0, C_RUN, 0, 0));
    t.push_back(mk(1, 1, 10, 1, 10, 0, 0, 0, C_LU, 1, 0));
    t.push_back(mk(1, 0, 0, 1, 10, 0, 0, 0, C_RUN, 1, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (w_ctl !== e.ctl) begin
        errors++;
        $display("FAIL no_stall[%0d] ctl got %b want %b", i, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({stall_count, mem_timeout} !== {e.cnt, e.to}) begin
        errors++;
        $display("FAIL no_stall[%0d] cnt/to got %0d/%b want %0d/%b", i, stall_count, mem_timeout, e.cnt, e.to);
      end
      $display("no_stall[%0d] ctl=%b cnt=%0d to=%b", i, w_ctl, stall_count, mem_timeout);
    end
  endtask

  task automatic test_branch();
    step_t t[$];
    step_t e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 0, 0));
    t.push_back(mk(1, 1, 8, 8, 0, 1, 0, 0, C_BR, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (w_ctl !== e.ctl) begin
        errors++;
        $display("FAIL branch[%0d] ctl got %b want %b", i, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({stall_count, mem_timeout} !== {e.cnt, e.to}) begin
        errors++;
        $display("FAIL branch[%0d] cnt/to got %0d/%b want %0d/%b", i, stall_count, mem_timeout, e.cnt, e.to);
      end
      $display("branch[%0d] ctl=%b cnt=%0d to=%b", i, w_ctl, stall_count, mem_timeout);
    end
  endtask

  task automatic test_mem_wait();
    step_t t[$];
    step_t e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 2, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 3, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, C_BR, 3, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 3, 0));
    // Reset in the middle of a wait must restart the timeout window.
    t.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 4, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0));
    for (int k = 1; k <= 4; k++) t.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, k, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, C_RUN, 4, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (w_ctl !== e.ctl) begin
        errors++;
        $display("FAIL mem_wait[%0d] ctl got %b want %b", i, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({stall_count, mem_timeout} !== {e.cnt, e.to}) begin
        errors++;
        $display("FAIL mem_wait[%0d] cnt/to got %0d/%b want %0d/%b", i, stall_count, mem_timeout, e.cnt, e.to);
      end
      $display("mem_wait[%0d] ctl=%b cnt=%0d to=%b", i, w_ctl, stall_count, mem_timeout);
    end
  endtask

  task automatic test_timeout();
    step_t t[$];
    step_t e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 0, 0));
    for (int k = 1; k <= 5; k++) t.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, k, (k == 5) ? 1 : 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, C_FRZ, 6, 1));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, C_FRZ, 7, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (w_ctl !== e.ctl) begin
        errors++;
        $display("FAIL timeout[%0d] ctl got %b want %b", i, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({stall_count, mem_timeout} !== {e.cnt, e.to}) begin
        errors++;
        $display("FAIL timeout[%0d] cnt/to got %0d/%b want %0d/%b", i, stall_count, mem_timeout, e.cnt, e.to);
      end
      $display("timeout[%0d] ctl=%b cnt=%0d to=%b", i, w_ctl, stall_count, mem_timeout);
    end
  endtask

  task automatic test_saturation();
    step_t t[$];
    step_t e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 0, 0));
    for (int k = 1; k <= 20; k++) t.push_back(mk(1, 1, 7, 7, 0, 0, 0, 0, C_LU, (k > 15) ? 15 : k, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 15, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (w_ctl !== e.ctl) begin
        errors++;
        $display("FAIL saturation[%0d] ctl got %b want %b", i, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({stall_count, mem_timeout} !== {e.cnt, e.to}) begin
        errors++;
        $display("FAIL saturation[%0d] cnt/to got %0d/%b want %0d/%b", i, stall_count, mem_timeout, e.cnt, e.to);
      end
      $display("saturation[%0d] ctl=%b cnt=%0d to=%b", i, w_ctl, stall_count, mem_timeout);
    end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    step_t e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 0, 0));
    t.push_back(mk(1, 1, 3, 3, 0, 0, 0, 0, C_LU, 1, 0));
    t.push_back(mk(1, 1, 3, 3, 0, 1, 0, 0, C_BR, 1, 0));
    t.push_back(mk(1, 1, 31, 2, 31, 0, 0, 0, C_LU, 2, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2, 0));
    t.push_back(mk(1, 1, 5, 5, 0, 0, 1, 0, C_FRZ, 3, 0));
    t.push_back(mk(1, 1, 5, 5, 0, 0, 1, 1, C_LU, 4, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 4, 0));
    foreach (t[i]) begin
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (w_ctl !== e.ctl) begin
        errors++;
        $display("FAIL back_to_back[%0d] ctl got %b want %b", i, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({stall_count, mem_timeout} !== {e.cnt, e.to}) begin
        errors++;
        $display("FAIL back_to_back[%0d] cnt/to got %0d/%b want %0d/%b", i, stall_count, mem_timeout, e.cnt, e.to);
      end
      $display("back_to_back[%0d] ctl=%b cnt=%0d to=%b", i, w_ctl, stall_count, mem_timeout);
    end
  endtask

  initial begin
    reset           = 1'b0;
    idex_memread    = 1'b0;
    idex_rt         = '0;
    ifid_rs         = '0;
    ifid_rt         = '0;
    branch_taken    = 1'b0;
    exmem_memaccess = 1'b0;
    mem_ready       = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
